multicycle_add_sub: RTL and testbench

- Parametrised N-bit adder/subtractor that processes operands CHUNK bits per clock, LSB slice first, with the carry held in a register between slices.
- Successor to the fixed 4-bit combinational ripple adder, adding:
  - generic width;
  - a subtract mode;
  - a start/busy/done handshake;
  - registered results;
  - status flags (carry, signed overflow, zero, negative).
- Datapath primitive for the ALU; trades latency for a short critical path.

---
 rtl/multicycle_add_sub.sv | 110 +++++++++++
 tb/tb_multicycle_add_sub.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_add_sub.sv
// Multi-cycle N-bit adder/subtractor: processes CHUNK bits per clock, LSB slice first,
// with a start/busy/done handshake and registered result plus status flags.
module multicycle_add_sub #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow,
  output logic             zero,
  output logic             negative
);

  localparam int unsigned NCHUNK = WIDTH / CHUNK;
  localparam int unsigned CntW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(NCHUNK - 1);

  if (WIDTH < 2 || (WIDTH % CHUNK) != 0) begin : g_bad_params
    $error("multicycle_add_sub: WIDTH must be >= 2 and a multiple of CHUNK");
  end

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] psum_q;
  logic             carry_q;
  logic             a_msb_q;
  logic             b_msb_q;
  logic [CntW-1:0]  cnt_q;

  logic [CHUNK:0]         slice_sum;
  logic [WIDTH+CHUNK-1:0] shifted;
  logic [WIDTH-1:0]       psum_next;

  // Operands shift right each cycle so the active slice is always in the low CHUNK bits;
  // the partial sum fills in from the top so it is fully aligned after the last slice.
  always_comb begin
    slice_sum = {1'b0, a_q[CHUNK-1:0]} + {1'b0, b_q[CHUNK-1:0]} + {{CHUNK{1'b0}}, carry_q};
    shifted   = {slice_sum[CHUNK-1:0], psum_q};
    psum_next = shifted[WIDTH+CHUNK-1:CHUNK];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      a_q      <= '0;
      b_q      <= '0;
      psum_q   <= '0;
      carry_q  <= 1'b0;
      a_msb_q  <= 1'b0;
      b_msb_q  <= 1'b0;
      cnt_q    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      sum      <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
      zero     <= 1'b0;
      negative <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          done <= 1'b0;
          if (start) begin
            a_q     <= a;
            b_q     <= sub ? ~b : b;
            a_msb_q <= a[WIDTH-1];
            b_msb_q <= sub ? ~b[WIDTH-1] : b[WIDTH-1];
            carry_q <= sub ? 1'b1 : cin;
            cnt_q   <= '0;
            busy    <= 1'b1;
            state_q <= StRun;
          end else begin
            state_q <= StIdle;
          end
        end
        StRun: begin
          a_q     <= a_q >> CHUNK;
          b_q     <= b_q >> CHUNK;
          psum_q  <= psum_next;
          carry_q <= slice_sum[CHUNK];
          cnt_q   <= cnt_q + CntW'(1);
          if (cnt_q == LastCnt) begin
            sum      <= psum_next;
            cout     <= slice_sum[CHUNK];
            overflow <= (a_msb_q == b_msb_q) && (psum_next[WIDTH-1] != a_msb_q);
            zero     <= (psum_next == '0);
            negative <= psum_next[WIDTH-1];
            busy     <= 1'b0;
            done     <= 1'b1;
            state_q  <= StDone;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_add_sub.sv
// Self-checking bench for multicycle_add_sub: directed handshake/flag cases on a 16/4
// instance plus randomized sweeps of 8/8, 8/1 and 32/8 against an arithmetic model.
module tb_multicycle_add_sub;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  start;
  logic        sub_in;
  logic        cin_in;
  logic [31:0] a_in;
  logic [31:0] b_in;

  wire [3:0]  busy, done, cout, ovf, zero, neg;
  wire [15:0] sum0;
  wire [7:0]  sum1, sum2;
  wire [31:0] sum3;
  logic [31:0] sum_v [4];

  int n_checks = 0;
  int n_fail   = 0;

  localparam int W  [4] = '{16, 8, 8, 32};
  localparam int NC [4] = '{4, 1, 8, 4};

  always #5 clk = ~clk;

  always_comb begin
    sum_v[0] = 32'(sum0);
    sum_v[1] = 32'(sum1);
    sum_v[2] = 32'(sum2);
    sum_v[3] = sum3;
  end

  multicycle_add_sub #(.WIDTH(16), .CHUNK(4)) u_dut0 (
    .clk(clk), .rst(rst), .start(start[0]), .sub(sub_in), .a(a_in[15:0]), .b(b_in[15:0]),
    .cin(cin_in), .busy(busy[0]), .done(done[0]), .sum(sum0), .cout(cout[0]),
    .overflow(ovf[0]), .zero(zero[0]), .negative(neg[0])
  );
  multicycle_add_sub #(.WIDTH(8), .CHUNK(8)) u_dut1 (
    .clk(clk), .rst(rst), .start(start[1]), .sub(sub_in), .a(a_in[7:0]), .b(b_in[7:0]),
    .cin(cin_in), .busy(busy[1]), .done(done[1]), .sum(sum1), .cout(cout[1]),
    .overflow(ovf[1]), .zero(zero[1]), .negative(neg[1])
  );
  multicycle_add_sub #(.WIDTH(8), .CHUNK(1)) u_dut2 (
    .clk(clk), .rst(rst), .start(start[2]), .sub(sub_in), .a(a_in[7:0]), .b(b_in[7:0]),
    .cin(cin_in), .busy(busy[2]), .done(done[2]), .sum(sum2), .cout(cout[2]),
    .overflow(ovf[2]), .zero(zero[2]), .negative(neg[2])
  );
  multicycle_add_sub #(.WIDTH(32), .CHUNK(8)) u_dut3 (
    .clk(clk), .rst(rst), .start(start[3]), .sub(sub_in), .a(a_in), .b(b_in),
    .cin(cin_in), .busy(busy[3]), .done(done[3]), .sum(sum3), .cout(cout[3]),
    .overflow(ovf[3]), .zero(zero[3]), .negative(neg[3])
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic on values, signed range test for overflow.
  task automatic model(input int w, input longint unsigned av, input longint unsigned bv,
                       input bit sb, input bit ci, output longint unsigned s,
                       output bit co, output bit ov, output bit z, output bit n);
    longint mask, full, sa, sbs, sr, lim;
    mask = (longint'(1) << w) - 1;
    sa   = av[w-1] ? longint'(av) - (longint'(1) << w) : longint'(av);
    sbs  = bv[w-1] ? longint'(bv) - (longint'(1) << w) : longint'(bv);
    if (sb) begin
      full = longint'(av) - longint'(bv);
      co   = (av >= bv);
      sr   = sa - sbs;
    end else begin
      full = longint'(av) + longint'(bv) + longint'(ci);
      co   = full[w];
      sr   = sa + sbs + longint'(ci);
    end
    s   = longint'(full & mask);
    lim = longint'(1) << (w - 1);
    ov  = (sr >= lim) || (sr < -lim);
    z   = (s == 0);
    n   = s[w-1];
  endtask

  task automatic check_res(input string tag, input int k, input longint unsigned s,
                           input bit co, input bit ov, input bit z, input bit n);
    chk({tag, "_sum"}, 64'(sum_v[k]), s);
    chk({tag, "_cout"}, 64'(cout[k]), 64'(co));
    chk({tag, "_ovf"}, 64'(ovf[k]), 64'(ov));
    chk({tag, "_zero"}, 64'(zero[k]), 64'(z));
    chk({tag, "_neg"}, 64'(neg[k]), 64'(n));
  endtask

  // Issue one request; afterwards the operand inputs are scrambled, which must not matter.
  task automatic launch(input int k, input longint unsigned av, input longint unsigned bv,
                        input bit sb, input bit ci);
    a_in     = 32'(av);
    b_in     = 32'(bv);
    sub_in   = sb;
    cin_in   = ci;
    start[k] = 1'b1;
    step();
    start[k] = 1'b0;
    a_in     = $urandom;
    b_in     = $urandom;
    sub_in   = 1'($urandom);
    cin_in   = 1'($urandom);
  endtask

  task automatic op(input string tag, input int k, input longint unsigned av,
                    input longint unsigned bv, input bit sb, input bit ci);
    int lat;
    longint unsigned s;
    bit co, ov, z, n;
    launch(k, av, bv, sb, ci);
    lat = 1;
    while (done[k] !== 1'b1 && lat < 200) begin
      step();
      lat++;
    end
    chk({tag, "_latency"}, 64'(lat), 64'(NC[k] + 1));
    model(W[k], av, bv, sb, ci, s, co, ov, z, n);
    check_res(tag, k, s, co, ov, z, n);
    step();
    chk({tag, "_done_pulse"}, 64'(done[k]), 64'd0);
  endtask

  initial begin
    longint unsigned mask, av, bv;
    rst    = 1'b1;
    start  = '0;
    sub_in = 1'b0;
    cin_in = 1'b0;
    a_in   = '0;
    b_in   = '0;
    step();
    step();
    for (int k = 0; k < 4; k++) begin
      chk("reset_busy", 64'(busy[k]), 64'd0);
      chk("reset_done", 64'(done[k]), 64'd0);
      check_res("reset", k, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    rst = 1'b0;
    step();

    // Basic add with explicit busy window.
    launch(0, 64'h0002, 64'h0005, 1'b0, 1'b0);
    for (int c = 1; c <= 4; c++) begin
      chk("add_busy", 64'(busy[0]), 64'd1);
      chk("add_done_early", 64'(done[0]), 64'd0);
      step();
    end
    chk("add_done", 64'(done[0]), 64'd1);
    chk("add_busy_end", 64'(busy[0]), 64'd0);
    check_res("add_2_5", 0, 64'h0007, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    chk("add_done_pulse", 64'(done[0]), 64'd0);
    check_res("add_hold", 0, 64'h0007, 1'b0, 1'b0, 1'b0, 1'b0);

    // Flag corner cases, constants taken directly from the arithmetic.
    op("ffff_p1", 0, 64'hFFFF, 64'h0001, 1'b0, 1'b0);
    check_res("ffff_p1_k", 0, 64'h0000, 1'b1, 1'b0, 1'b1, 1'b0);
    op("7fff_cin", 0, 64'h7FFF, 64'h0000, 1'b0, 1'b1);
    check_res("7fff_cin_k", 0, 64'h8000, 1'b0, 1'b1, 1'b0, 1'b1);
    op("sub_5_7", 0, 64'h0005, 64'h0007, 1'b1, 1'b1);
    check_res("sub_5_7_k", 0, 64'hFFFE, 1'b0, 1'b0, 1'b0, 1'b1);
    op("sub_8000_1", 0, 64'h8000, 64'h0001, 1'b1, 1'b0);
    check_res("sub_8000_1_k", 0, 64'h7FFF, 1'b1, 1'b1, 1'b0, 1'b0);

    // start held high: restart taken in the DONE cycle, later starts in RUN ignored.
    a_in     = 32'h1234;
    b_in     = 32'h1111;
    sub_in   = 1'b0;
    cin_in   = 1'b0;
    start[0] = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      step();
      if (c == 2) a_in = 32'hFFFF;
      if (c == 5) begin
        chk("hold_done1", 64'(done[0]), 64'd1);
        check_res("hold_first", 0, 64'h2345, 1'b0, 1'b0, 1'b0, 1'b0);
      end else if (c == 10) begin
        chk("hold_done2", 64'(done[0]), 64'd1);
        check_res("hold_second", 0, 64'h1110, 1'b1, 1'b0, 1'b0, 1'b0);
      end else begin
        chk("hold_no_done", 64'(done[0]), 64'd0);
      end
      if (c >= 6 && c <= 9) begin
        chk("hold_rerun_busy", 64'(busy[0]), 64'd1);
        chk("hold_sum_kept", 64'(sum_v[0]), 64'h2345);
      end
    end
    start[0] = 1'b0;
    step();

    // Reset in the middle of RUN aborts the operation.
    launch(0, 64'h00FF, 64'h0001, 1'b0, 1'b0);
    step();
    chk("abort_busy_pre", 64'(busy[0]), 64'd1);
    chk("abort_sum_held", 64'(sum_v[0]), 64'h1110);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_busy", 64'(busy[0]), 64'd0);
    chk("abort_done", 64'(done[0]), 64'd0);
    check_res("abort", 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int c = 0; c < 10; c++) begin
      step();
      chk("abort_quiet", 64'(done[0]), 64'd0);
    end
    op("after_abort", 0, 64'h00FF, 64'h0001, 1'b0, 1'b0);
    check_res("after_abort_k", 0, 64'h0100, 1'b0, 1'b0, 1'b0, 1'b0);

    // Randomized sweeps; the 16/4 instance gets a few too.
    for (int k = 0; k < 4; k++) begin
      mask = (longint'(1) << W[k]) - 1;
      for (int i = 0; i < ((k == 0) ? 50 : 200); i++) begin
        av = longint'($urandom) & mask;
        bv = longint'($urandom) & mask;
        if (i % 16 == 0) av = mask;
        if (i % 16 == 1) bv = av;
        op($sformatf("rand_k%0d_%0d", k, i), k, av, bv, 1'($urandom), 1'($urandom));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
